spwm_capture: RTL and testbench
===============================

// Module: spwm_capture
// PURPOSE
//  Receive-side counterpart of the SPWM generator: samples the pwm_Pos/pwm_Neg pair, rebuilds the modulation.
//  Per carrier window: reports high-time and polarity. Per half-cycle: reports window count (fundamental
//  frequency). Flags shoot-through and signal loss. Sits beside the inverter bridge as monitor/test receiver.
// PARAMETERS
//  W           16     width of carrier counters and sample_width
//  PERIOD      10000  carrier period in clocks (must equal generator period)
//  CW          7      width of half-cycle window counter and half_len
//  LOS_WINDOWS 4      consecutive all-low windows that declare loss of signal
// PORTS
//  clock        in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  pwm_Pos      in   1   positive-half PWM, asynchronous to clock
//  pwm_Neg      in   1   negative-half PWM, asynchronous to clock
//  sample_valid out  1   one-cycle pulse at end of each carrier window
//  sample_width out  W   clocks the dominant input was high in that window (0..PERIOD)
//  sample_neg   out  1   1 = window belongs to the negative half-cycle
//  half_valid   out  1   one-cycle pulse at each half-cycle boundary
//  half_len     out  CW  windows counted in the half-cycle just ended
//  locked       out  1   two consecutive half-cycle boundaries seen, no loss since
//  fault        out  1   sticky: pwm_Pos and pwm_Neg synchronized high in the same cycle
// BEHAVIOUR
//  - Reset (reset=0): every output and internal register 0, state IDLE; immediate, asynchronous.
//  - Inputs pass a 2-FF synchronizer; all timing below is in synchronized-domain cycles (+2 clock latency).
//  - FSM: IDLE -> POS / NEG on first synced rising edge (POS if pwm_Pos rose, NEG if pwm_Neg; Pos wins on tie).
//    POS <-> NEG at half-cycle boundary; any state -> FAULT on overlap; POS/NEG -> IDLE on loss of signal.
//    FAULT is terminal until reset; in FAULT all pulses stay 0, data outputs hold last values.
//  - Window: win_cnt loads 0 on the edge cycle that leaves IDLE, increments every cycle, wraps at PERIOD-1.
//    pos_hi/neg_hi count cycles each synced input is high, including the wrap cycle.
//  - End of window (win_cnt==PERIOD-1), registered, outputs valid the following cycle:
//    sample_valid=1; sample_neg = (neg_hi > pos_hi), ties keep current state polarity;
//    sample_width = max(pos_hi, neg_hi); counters clear for the next window.
//  - Half-cycle boundary: window with nonzero count on the polarity opposite to state. On that window:
//    half_valid=1 together with sample_valid, half_len = windows of ended half (boundary window excluded,
//    counts as window 1 of the new half), state flips. All-zero windows (zero crossing) count toward current half.
//  - half counter saturates at 2^CW-1; no wrap.
//  - locked: set on second boundary after leaving IDLE; cleared on entering IDLE or FAULT.
//  - Loss of signal: LOS_WINDOWS consecutive windows with pos_hi==neg_hi==0 -> IDLE, locked=0,
//    window and half counters cleared; the window producing the transition still emits sample_valid (width 0).
//  - fault: set the cycle after both synced inputs are high; overrides an end-of-window in the same cycle.
//  - Edges arriving mid-window never realign win_cnt; alignment happens only when leaving IDLE.
// STRUCTURE
//  - spwm_pkg: state enum (IDLE, POS, NEG, FAULT), default PERIOD, W, CW constants shared with the generator.
//  - Sub-module pwm_sync_edge (2-FF synchronizer + rising-edge detect), instantiated for pwm_Pos and pwm_Neg.
//  - Top holds FSM, window counter, two high-time counters, half counter, LOS counter, output registers.
// TESTING
//  1. pwm_Pos 2500/10000 duty, pwm_Neg low -> sample_valid every 10000 clk, sample_width=2500, sample_neg=0.
//  2. 5 windows Pos (duty 3000) then 5 windows Neg (duty 3000), repeated -> half_valid each 5 windows,
//     half_len=5, sample_neg toggles per half, locked=1 from second boundary onward.
//  3. pwm_Pos and pwm_Neg high together for 1 clk -> fault=1 3 clk later, no further pulses; reset clears.
//  4. Lock, then both inputs low 4 windows -> 4th window emits width 0, locked=0, then no sample_valid.
//  5. Duty 10000 (Pos constantly high) -> sample_width=10000; duty-0 windows inside a half add to half_len.
//  6. Assert reset mid-window while locked -> all outputs 0 same cycle; after release waits for fresh edge.

Source files
------------

// File: rtl/spwm_pkg.sv
// spwm_pkg: constants and state type shared by the SPWM generator and the
// SPWM capture receiver, so both sides agree on carrier period and widths.
package spwm_pkg;

  localparam int unsigned SPWM_W           = 16;     // carrier counter / width field
  localparam int unsigned SPWM_PERIOD      = 10000;  // carrier period in clocks
  localparam int unsigned SPWM_CW          = 7;      // half-cycle window counter width
  localparam int unsigned SPWM_LOS_WINDOWS = 4;      // all-low windows meaning signal lost

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POS   = 2'd1,
    NEG   = 2'd2,
    FAULT = 2'd3
  } spwm_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: brings one asynchronous PWM line into the clock domain with a
// two-flop synchronizer and flags its rising edge.
//   clock    in  system clock
//   reset    in  asynchronous active-low reset
//   i_async  in  raw PWM input
//   o_level  out synchronized level (2 clocks of latency)
//   o_rise   out one-cycle pulse on a synchronized 0->1 transition
module pwm_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/spwm_capture.sv
// spwm_capture: receive-side monitor for an SPWM pwm_Pos/pwm_Neg pair.
// Measures the dominant high time of every carrier window, tracks half-cycles
// (fundamental frequency), and flags shoot-through and loss of signal.
//   clock, reset          system clock, asynchronous active-low reset
//   pwm_Pos, pwm_Neg      asynchronous PWM inputs
//   sample_valid          pulse at end of each carrier window
//   sample_width          dominant high time of that window (0..PERIOD)
//   sample_neg            window belongs to negative half-cycle
//   half_valid, half_len  pulse at half-cycle boundary, windows in ended half
//   locked                two boundaries seen with no loss since
//   fault                 sticky overlap of synchronized inputs
module spwm_capture
  import spwm_pkg::*;
#(
  parameter int unsigned W           = SPWM_W,
  parameter int unsigned PERIOD      = SPWM_PERIOD,
  parameter int unsigned CW          = SPWM_CW,
  parameter int unsigned LOS_WINDOWS = SPWM_LOS_WINDOWS
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pwm_Pos,
  input  logic          pwm_Neg,
  output logic          sample_valid,
  output logic [W-1:0]  sample_width,
  output logic          sample_neg,
  output logic          half_valid,
  output logic [CW-1:0] half_len,
  output logic          locked,
  output logic          fault
);

  localparam int unsigned   LW       = $clog2(LOS_WINDOWS + 1);
  localparam logic [W-1:0]  WIN_LAST = W'(PERIOD - 1);
  localparam logic [LW-1:0] LOS_LAST = LW'(LOS_WINDOWS - 1);

  logic          w_pos_lvl, w_pos_rise, w_neg_lvl, w_neg_rise;
  spwm_state_e   r_state, w_state_nxt;
  logic [W-1:0]  r_win_cnt, r_pos_hi, r_neg_hi;
  logic [W-1:0]  w_pos_tot, w_neg_tot;
  logic [CW-1:0] r_half_cnt;
  logic [LW-1:0] r_los_cnt;
  logic          r_bnd_seen;
  logic          r_sample_valid, r_sample_neg, r_half_valid, r_locked, r_fault;
  logic [W-1:0]  r_sample_width;
  logic [CW-1:0] r_half_len;
  logic          w_overlap, w_run, w_eow, w_zero, w_boundary, w_los;

  pwm_sync_edge u_sync_pos (
    .clock  (clock),
    .reset  (reset),
    .i_async(pwm_Pos),
    .o_level(w_pos_lvl),
    .o_rise (w_pos_rise)
  );

  pwm_sync_edge u_sync_neg (
    .clock  (clock),
    .reset  (reset),
    .i_async(pwm_Neg),
    .o_level(w_neg_lvl),
    .o_rise (w_neg_rise)
  );

  assign w_overlap = w_pos_lvl & w_neg_lvl;
  // win_cnt sits at 0 while idle, so the edge cycle that leaves IDLE is
  // window position 0 and is counted like any other cycle of the window.
  assign w_run = (r_state == POS) || (r_state == NEG) ||
                 ((r_state == IDLE) && (w_pos_rise || w_neg_rise));
  // Totals include the current cycle, so the wrap cycle is counted.
  assign w_pos_tot  = r_pos_hi + W'(w_pos_lvl);
  assign w_neg_tot  = r_neg_hi + W'(w_neg_lvl);
  assign w_eow      = w_run && (r_win_cnt == WIN_LAST);
  assign w_zero     = (w_pos_tot == '0) && (w_neg_tot == '0);
  assign w_boundary = w_eow && (((r_state == POS) && (w_neg_tot != '0)) ||
                                ((r_state == NEG) && (w_pos_tot != '0)));
  assign w_los      = w_eow && w_zero && (r_los_cnt == LOS_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pos_rise) w_state_nxt = POS;
               else if (w_neg_rise) w_state_nxt = NEG;
      POS:     if (w_boundary) w_state_nxt = NEG;
               else if (w_los) w_state_nxt = IDLE;
      NEG:     if (w_boundary) w_state_nxt = POS;
               else if (w_los) w_state_nxt = IDLE;
      default: w_state_nxt = FAULT;
    endcase
    if (w_overlap) w_state_nxt = FAULT;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_win_cnt      <= '0;
      r_pos_hi       <= '0;
      r_neg_hi       <= '0;
      r_half_cnt     <= '0;
      r_los_cnt      <= '0;
      r_bnd_seen     <= 1'b0;
      r_sample_valid <= 1'b0;
      r_sample_width <= '0;
      r_sample_neg   <= 1'b0;
      r_half_valid   <= 1'b0;
      r_half_len     <= '0;
      r_locked       <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_half_valid   <= 1'b0;
      if (w_overlap) begin
        // Overlap wins over a coinciding end of window.
        r_fault  <= 1'b1;
        r_locked <= 1'b0;
      end else if (w_run) begin
        if (!w_eow) begin
          r_win_cnt <= r_win_cnt + W'(1);
          r_pos_hi  <= w_pos_tot;
          r_neg_hi  <= w_neg_tot;
        end else begin
          r_win_cnt      <= '0;
          r_pos_hi       <= '0;
          r_neg_hi       <= '0;
          r_sample_valid <= 1'b1;
          r_sample_width <= (w_pos_tot > w_neg_tot) ? w_pos_tot : w_neg_tot;
          if (w_neg_tot > w_pos_tot)      r_sample_neg <= 1'b1;
          else if (w_pos_tot > w_neg_tot) r_sample_neg <= 1'b0;
          else                            r_sample_neg <= (r_state == NEG);
          if (w_los) begin
            r_los_cnt  <= '0;
            r_half_cnt <= '0;
            r_bnd_seen <= 1'b0;
            r_locked   <= 1'b0;
          end else if (w_boundary) begin
            // Boundary window opens the new half as its first window.
            r_half_valid <= 1'b1;
            r_half_len   <= r_half_cnt;
            r_half_cnt   <= CW'(1);
            r_los_cnt    <= '0;
            r_bnd_seen   <= 1'b1;
            if (r_bnd_seen) r_locked <= 1'b1;
          end else begin
            r_half_cnt <= (r_half_cnt == '1) ? r_half_cnt : r_half_cnt + CW'(1);
            r_los_cnt  <= w_zero ? r_los_cnt + LW'(1) : '0;
          end
        end
      end
    end
  end

  assign sample_valid = r_sample_valid;
  assign sample_width = r_sample_width;
  assign sample_neg   = r_sample_neg;
  assign half_valid   = r_half_valid;
  assign half_len     = r_half_len;
  assign locked       = r_locked;
  assign fault        = r_fault;

endmodule

// File: tb/tb_spwm_capture.sv
// tb_spwm_capture: drives generator-aligned PWM windows (given as per-window
// high counts) into spwm_capture and compares every reported window against
// a window-level reference model of the capture rules.
`timescale 1ns/1ps
module tb_spwm_capture;

  localparam int unsigned P    = 40;
  localparam int unsigned TW   = 16;
  localparam int unsigned TCW  = 3;
  localparam int unsigned LOSW = 4;
  localparam int unsigned HMAX = (1 << TCW) - 1;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           pos   = 1'b0;
  logic           neg   = 1'b0;
  logic           sv;
  logic [TW-1:0]  sw;
  logic           sn;
  logic           hv;
  logic [TCW-1:0] hl;
  logic           lk;
  logic           flt;

  typedef struct packed {
    logic [TW-1:0]  width;
    logic           neg;
    logic           half;
    logic [TCW-1:0] hlen;
    logic           lock;
  } ev_t;

  ev_t         obs[$];
  ev_t         exp_q[$];
  int unsigned obs_t[$];
  int unsigned g_dp[$];
  int unsigned g_dn[$];
  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  spwm_capture #(.W(TW), .PERIOD(P), .CW(TCW), .LOS_WINDOWS(LOSW)) dut (
    .clock       (clk),
    .reset       (rst_n),
    .pwm_Pos     (pos),
    .pwm_Neg     (neg),
    .sample_valid(sv),
    .sample_width(sw),
    .sample_neg  (sn),
    .half_valid  (hv),
    .half_len    (hl),
    .locked      (lk),
    .fault       (flt)
  );

  always #5 clk = ~clk;

  task automatic sample_cycle();
    ev_t e;
    @(negedge clk);
    cyc++;
    if (sv || hv) begin
      e.width = sw;
      e.neg   = sn;
      e.half  = hv;
      e.hlen  = hv ? hl : '0;
      e.lock  = lk;
      obs.push_back(e);
      obs_t.push_back(cyc);
    end
  endtask

  // Each window: the active line is high for its count from the window start.
  task automatic play(input int unsigned flush);
    for (int k = 0; k < g_dp.size(); k++) begin
      for (int unsigned c = 0; c < P; c++) begin
        sample_cycle();
        pos = (c < g_dp[k]);
        neg = (c < g_dn[k]);
      end
    end
    for (int unsigned c = 0; c < flush; c++) begin
      sample_cycle();
      pos = 1'b0;
      neg = 1'b0;
    end
  endtask

  function automatic void push_win(input int unsigned n, input int unsigned dp,
                                   input int unsigned dn);
    for (int unsigned i = 0; i < n; i++) begin
      g_dp.push_back(dp);
      g_dn.push_back(dn);
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pos   = 1'b0;
    neg   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    obs.delete();
    obs_t.delete();
    g_dp.delete();
    g_dn.delete();
  endtask

  // Window-level reference: polarity, half length, loss and lock bookkeeping.
  function automatic void build_model();
    bit          run = 1'b0;
    bit          pol = 1'b0;
    bit          lck = 1'b0;
    int unsigned hn = 0, zr = 0, nb = 0;
    exp_q.delete();
    for (int k = 0; k < g_dp.size(); k++) begin
      int unsigned a = g_dp[k];
      int unsigned b = g_dn[k];
      ev_t e;
      if (!run) begin
        if (a == 0 && b == 0) continue;
        run = 1'b1; pol = (a == 0); hn = 0; zr = 0; nb = 0; lck = 1'b0;
      end
      e       = '0;
      e.width = TW'((a > b) ? a : b);
      e.neg   = (b > a) ? 1'b1 : ((a > b) ? 1'b0 : pol);
      if (a == 0 && b == 0) begin
        zr++;
        if (zr == LOSW) begin
          run = 1'b0;
          lck = 1'b0;
        end else begin
          hn = (hn < HMAX) ? hn + 1 : hn;
        end
      end else begin
        zr = 0;
        if ((!pol && b != 0) || (pol && a != 0)) begin
          e.half = 1'b1;
          e.hlen = TCW'(hn);
          hn     = 1;
          pol    = ~pol;
          nb++;
          if (nb >= 2) lck = 1'b1;
        end else begin
          hn = (hn < HMAX) ? hn + 1 : hn;
        end
      end
      e.lock = lck;
      exp_q.push_back(e);
    end
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({sv, sw, sn, hv, hl, lk, flt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got sv=%b w=%0d n=%b hv=%b hl=%0d lk=%b f=%b want all 0",
               sv, sw, sn, hv, hl, lk, flt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_pos();
    do_reset();
    push_win(4, P / 4, 0);
    push_win(4, 0, 0);
    play(8);
    build_model();
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL single_count got=%0d want=%0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL single_ev%0d got w=%0d n=%b h=%b l=%0d k=%b want w=%0d n=%b h=%b l=%0d k=%b",
                 i, obs[i].width, obs[i].neg, obs[i].half, obs[i].hlen, obs[i].lock,
                 exp_q[i].width, exp_q[i].neg, exp_q[i].half, exp_q[i].hlen, exp_q[i].lock);
      end
    end
    if (obs_t.size() >= 2) begin
      total++;
      if (obs_t[1] - obs_t[0] != P) begin
        bad++;
        $display("FAIL single_spacing got=%0d want=%0d", obs_t[1] - obs_t[0], P);
      end
    end
  endtask

  task automatic test_halves();
    int unsigned nhalf = 0;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      push_win(5, 12, 0);
      push_win(5, 0, 12);
    end
    push_win(4, 0, 0);
    play(8);
    build_model();
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL halves_count got=%0d want=%0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL halves_ev%0d got w=%0d n=%b h=%b l=%0d k=%b want w=%0d n=%b h=%b l=%0d k=%b",
                 i, obs[i].width, obs[i].neg, obs[i].half, obs[i].hlen, obs[i].lock,
                 exp_q[i].width, exp_q[i].neg, exp_q[i].half, exp_q[i].hlen, exp_q[i].lock);
      end
    end
    foreach (obs[i]) if (obs[i].half && obs[i].hlen == 5) nhalf++;
    total++;
    if (nhalf != 5) begin
      bad++;
      $display("FAIL halves_len5 got=%0d want=5", nhalf);
    end
  endtask

  task automatic test_fault();
    int unsigned lat  = 0;
    bit          seen = 1'b0;
    do_reset();
    push_win(2, 12, 0);
    play(8);
    obs.delete();
    @(negedge clk);
    pos = 1'b1;
    neg = 1'b1;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      pos = 1'b0;
      neg = 1'b0;
      if (flt) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    total++;
    if (!seen || lat != 3) begin
      bad++;
      $display("FAIL fault_latency got seen=%b lat=%0d want seen=1 lat=3", seen, lat);
    end
    g_dp.delete();
    g_dn.delete();
    push_win(3, P / 2, 0);
    play(8);
    total++;
    if (obs.size() != 0) begin
      bad++;
      $display("FAIL fault_no_pulses got=%0d want=0", obs.size());
    end
    total++;
    if ({flt, lk, sw} !== {1'b1, 1'b0, TW'(12)}) begin
      bad++;
      $display("FAIL fault_hold got f=%b lk=%b w=%0d want f=1 lk=0 w=12", flt, lk, sw);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (flt !== 1'b0) begin
      bad++;
      $display("FAIL fault_reset got=%b want=0", flt);
    end
  endtask

  task automatic test_los();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push_win(5, 20, 0);
      push_win(5, 0, 20);
    end
    push_win(6, 0, 0);
    play(8);
    build_model();
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL los_count got=%0d want=%0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL los_ev%0d got w=%0d n=%b h=%b l=%0d k=%b want w=%0d n=%b h=%b l=%0d k=%b",
                 i, obs[i].width, obs[i].neg, obs[i].half, obs[i].hlen, obs[i].lock,
                 exp_q[i].width, exp_q[i].neg, exp_q[i].half, exp_q[i].hlen, exp_q[i].lock);
      end
    end
    total++;
    if (lk !== 1'b0) begin
      bad++;
      $display("FAIL los_unlocked got=%b want=0", lk);
    end
  endtask

  task automatic test_full_duty();
    do_reset();
    push_win(2, P, 0);
    push_win(1, 0, 0);
    push_win(2, P, 0);
    push_win(2, 0, P);
    push_win(9, 5, 0);
    push_win(1, 0, P);
    push_win(4, 0, 0);
    play(8);
    build_model();
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL full_count got=%0d want=%0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL full_ev%0d got w=%0d n=%b h=%b l=%0d k=%b want w=%0d n=%b h=%b l=%0d k=%b",
                 i, obs[i].width, obs[i].neg, obs[i].half, obs[i].hlen, obs[i].lock,
                 exp_q[i].width, exp_q[i].neg, exp_q[i].half, exp_q[i].hlen, exp_q[i].lock);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_win(5, 20, 0);
    push_win(5, 0, 20);
    push_win(5, 20, 0);
    play(15);
    total++;
    if (lk !== 1'b1) begin
      bad++;
      $display("FAIL midreset_prelock got=%b want=1", lk);
    end
    pos = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({sv, sw, sn, hv, hl, lk, flt} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got sv=%b w=%0d n=%b hv=%b hl=%0d lk=%b f=%b want all 0",
               sv, sw, sn, hv, hl, lk, flt);
    end
    pos = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    obs.delete();
    g_dp.delete();
    g_dn.delete();
    push_win(3, 0, 0);
    play(0);
    total++;
    if (obs.size() != 0) begin
      bad++;
      $display("FAIL midreset_idle got=%0d want=0", obs.size());
    end
    obs.delete();
    g_dp.delete();
    g_dn.delete();
    push_win(3, 0, 15);
    push_win(3, 15, 0);
    push_win(4, 0, 0);
    play(8);
    build_model();
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL midreset_count got=%0d want=%0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL midreset_ev%0d got w=%0d n=%b h=%b l=%0d k=%b want w=%0d n=%b h=%b l=%0d k=%b",
                 i, obs[i].width, obs[i].neg, obs[i].half, obs[i].hlen, obs[i].lock,
                 exp_q[i].width, exp_q[i].neg, exp_q[i].half, exp_q[i].hlen, exp_q[i].lock);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int unsigned nh;
      bit          p;
      do_reset();
      nh = $urandom_range(6, 4);
      p  = 1'($urandom_range(1, 0));
      for (int h = 0; h < nh; h++) begin
        int unsigned len = $urandom_range(9, 1);
        for (int unsigned w = 0; w < len; w++) begin
          int unsigned d = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(P, 1);
          push_win(1, p ? 0 : d, p ? d : 0);
        end
        p = ~p;
      end
      push_win(LOSW, 0, 0);
      play(8);
      build_model();
      total++;
      if (obs.size() != exp_q.size()) begin
        bad++;
        $display("FAIL random%0d_count got=%0d want=%0d", r, obs.size(), exp_q.size());
      end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
        total++;
        if (obs[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL random%0d_ev%0d got w=%0d n=%b h=%b l=%0d k=%b want w=%0d n=%b h=%b l=%0d k=%b",
                   r, i, obs[i].width, obs[i].neg, obs[i].half, obs[i].hlen, obs[i].lock,
                   exp_q[i].width, exp_q[i].neg, exp_q[i].half, exp_q[i].hlen, exp_q[i].lock);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pos();
    test_halves();
    test_fault();
    test_los();
    test_full_duty();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
